// File: rtl/test_logic_if.sv
// Signal bundle for the test_logic Boolean function block: four index inputs
// and the combinational/registered results.
interface test_logic_if;
  logic       a;
  logic       b;
  logic       c;
  logic       d;
  logic       f_comb;
  logic       f;
  logic [3:0] idx;
  logic       valid;

  modport master (
    output a, b, c, d,
    input  f_comb, f, idx, valid
  );

  modport slave (
    input  a, b, c, d,
    output f_comb, f, idx, valid
  );
endinterface

// File: rtl/test_logic.sv
// Four-input Boolean function of index {a,b,c,d} chosen by truth table TRUTH,
// built as an OR of decoded minterms, with a one-cycle registered copy.
module test_logic #(
  parameter logic [15:0] TRUTH = 16'h28AC
) (
  input  logic   clk,
  input  logic   rst,
  test_logic_if.slave bus
);

  logic [15:0] term_s;
  logic        f_comb_s;
  logic        f_r;
  logic [3:0]  idx_r;
  logic        valid_r;

  // One product term per set truth-table bit; clear bits contribute nothing.
  for (genvar k = 0; k < 16; k++) begin : g_minterm
    localparam logic [3:0] K = 4'(k);
    if (TRUTH[k]) begin : g_on
      assign term_s[k] = (K[3] ? bus.a : ~bus.a) &
                         (K[2] ? bus.b : ~bus.b) &
                         (K[1] ? bus.c : ~bus.c) &
                         (K[0] ? bus.d : ~bus.d);
    end else begin : g_off
      assign term_s[k] = 1'b0;
    end
  end

  assign f_comb_s = |term_s;

  // Sample the result and its index together so f always matches idx.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_r     <= 1'b0;
      idx_r   <= 4'h0;
      valid_r <= 1'b0;
    end else begin
      f_r     <= f_comb_s;
      idx_r   <= {bus.a, bus.b, bus.c, bus.d};
      valid_r <= 1'b1;
    end
  end

  assign bus.f_comb = f_comb_s;
  assign bus.f      = f_r;
  assign bus.idx    = idx_r;
  assign bus.valid  = valid_r;

endmodule

// File: tb/tb_test_logic.sv
// Scoreboard bench for test_logic: default (prime) table and a 16'h8001 override
// driven with identical stimulus and checked against arithmetic reference models.
module tb_test_logic;

  typedef struct {
    logic       v;
    logic [3:0] i;
    logic       f;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t q0[$];
  exp_t q1[$];

  test_logic_if bus0 ();
  test_logic_if bus1 ();

  test_logic dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  test_logic #(.TRUTH(16'h8001)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int k = 2; k < n; k++) begin
      if (n % k == 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit is_ends(input int n);
    return (n == 0) || (n == 15);
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, check combinational outputs, queue the registered ones.
  task automatic step(input logic r, input int n);
    exp_t e0;
    exp_t e1;
    logic [3:0] v;
    @(negedge clk);
    v   = 4'(n);
    rst = r;
    {bus0.a, bus0.b, bus0.c, bus0.d} = v;
    {bus1.a, bus1.b, bus1.c, bus1.d} = v;
    if (r) begin
      e0 = '{v: 1'b0, i: 4'h0, f: 1'b0};
      e1 = '{v: 1'b0, i: 4'h0, f: 1'b0};
    end else begin
      e0 = '{v: 1'b1, i: v, f: is_prime(n)};
      e1 = '{v: 1'b1, i: v, f: is_ends(n)};
    end
    q0.push_back(e0);
    q1.push_back(e1);
    #1;
    chk("f_comb_prime", {3'b000, bus0.f_comb}, {3'b000, is_prime(n)});
    chk("f_comb_8001", {3'b000, bus1.f_comb}, {3'b000, is_ends(n)});
  endtask

  // Monitor: after each edge compare registered outputs with the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("valid_prime", {3'b000, bus0.valid}, {3'b000, e.v});
        chk("idx_prime", bus0.idx, e.i);
        chk("f_prime", {3'b000, bus0.f}, {3'b000, e.f});
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("valid_8001", {3'b000, bus1.valid}, {3'b000, e.v});
        chk("idx_8001", bus1.idx, e.i);
        chk("f_8001", {3'b000, bus1.f}, {3'b000, e.f});
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    {bus0.a, bus0.b, bus0.c, bus0.d} = 4'hF;
    {bus1.a, bus1.b, bus1.c, bus1.d} = 4'hF;

    // Reset held with inputs all ones, then release.
    step(1'b1, 15);
    step(1'b1, 15);
    step(1'b0, 15);

    // Exhaustive sweep with a reset at index 11.
    for (int n = 0; n < 11; n++) step(1'b0, n);
    step(1'b1, 11);
    step(1'b0, 11);
    for (int n = 12; n < 16; n++) step(1'b0, n);

    // Latency: 3 then 4 on consecutive cycles.
    step(1'b0, 3);
    step(1'b0, 4);

    // Second full sweep without reset.
    for (int n = 0; n < 16; n++) step(1'b0, n);

    // Random inputs with occasional reset.
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0, int'($urandom_range(0, 15)));
    end
    step(1'b0, 0);

    // Let the monitor drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 5 && (q0.size() > 0 || q1.size() > 0); i++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending expected 0", q0.size(), q1.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got time %0t expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
